// File: rtl/eeprom_read_ctrl.sv
// eeprom_read_ctrl
// Read controller for a 32 KiB asynchronous EEPROM (28256) used as boot ROM.
// A request (start address + beat count) is accepted from the system side.
// The controller drives the EEPROM address and the active-low chip/output
// enables, and waits WAIT_CYCLES cycles per byte. It then registers the byte
// and offers it on a response port with backpressure. The EEPROM data bus is
// only ever read.
//
// Handshake rule for both req_* and rsp_* ports: a transfer happens on a rising
// clock edge where valid and ready are both high. A producer keeps valid and
// its payload stable until that edge. A consumer may change ready at any time.
//
// Ports
//   clock, reset          : sole clock; asynchronous active-high reset
//   req_valid/req_ready   : request handshake (req_ready = state is IDLE)
//   req_addr[14:0]        : first byte address
//   req_len[3:0]          : number of beats minus one (1..16 bytes)
//   rsp_valid/rsp_ready   : response handshake (rsp_valid = state is HOLD)
//   rsp_data[7:0]         : registered EEPROM byte
//   rsp_last              : final beat of the current request
//   busy                  : state is not IDLE
//   mem_addr[14:0]        : EEPROM address pins
//   mem_data[7:0]         : EEPROM data pins (input only)
//   mem_ce_n, mem_oe_n    : EEPROM chip/output enable, registered, active low
//   state_dbg[1:0]        : current FSM state (IDLE=0 ACCESS=1 HOLD=2 RECOVER=3)
module eeprom_read_ctrl #(
  parameter int WAIT_CYCLES = 4,  // 1..15
  parameter int TURNAROUND  = 1   // 0..7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [14:0] req_addr,
  input  logic [3:0]  req_len,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_last,
  output logic        busy,
  output logic [14:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;
  localparam logic [1:0] RECOVER = 2'd3;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
  localparam logic [2:0] TURN_LD = 3'(TURNAROUND);

  logic [1:0] state;
  logic [3:0] wait_cnt;   // access cycles left for the current byte
  logic [3:0] beat_cnt;   // beats remaining after the current one
  logic [2:0] turn_cnt;   // recovery cycles left
  logic       en_n;       // shared registered enable for CE# and OE#

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == HOLD);
  assign mem_ce_n  = en_n;
  assign mem_oe_n  = en_n;
  assign state_dbg = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      beat_cnt <= 4'd0;
      turn_cnt <= 3'd0;
      mem_addr <= 15'd0;
      en_n     <= 1'b1;
      rsp_data <= 8'h00;
      rsp_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state    <= ACCESS;
            mem_addr <= req_addr;
            beat_cnt <= req_len;
            wait_cnt <= WAIT_LD;
            en_n     <= 1'b0;
          end
        end

        ACCESS: begin
          wait_cnt <= wait_cnt - 4'd1;
          // Address has been stable for WAIT_CYCLES cycles at this edge.
          if (wait_cnt == 4'd1) begin
            rsp_data <= mem_data;
            rsp_last <= (beat_cnt == 4'd0);
            state    <= HOLD;
          end
        end

        HOLD: begin
          if (rsp_ready) begin
            if (beat_cnt != 4'd0) begin
              // Sequential read: enables stay low, address wraps at 0x7FFF.
              mem_addr <= mem_addr + 15'd1;
              beat_cnt <= beat_cnt - 4'd1;
              wait_cnt <= WAIT_LD;
              state    <= ACCESS;
            end else begin
              en_n     <= 1'b1;
              turn_cnt <= TURN_LD;
              state    <= (TURNAROUND == 0) ? IDLE : RECOVER;
            end
          end
        end

        RECOVER: begin
          if (turn_cnt <= 3'd1) begin
            state <= IDLE;
          end else begin
            turn_cnt <= turn_cnt - 3'd1;
          end
        end

        default: begin
          state <= IDLE;
          en_n  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_read_ctrl.sv
// Testbench for eeprom_read_ctrl. A combinational EEPROM model answers every
// address. Expected beats {addr, last, data} are queued when a request is
// driven and are compared when the response handshake happens. Two extra
// instances with TURNAROUND=3 and TURNAROUND=0 run back-to-back reads so that
// their enable-high gaps can be measured.
module tb_eeprom_read_ctrl;

  localparam int WAIT = 4;
  localparam int TA   = 1;
  localparam logic [1:0] S_ACCESS = 2'd1;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  int   cyc;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- EEPROM model ----------------
  function automatic logic [7:0] mem_fn(input logic [14:0] a);
    if (a == 15'h0123) return 8'hA5;
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h3C;
  endfunction

  // ---------------- main DUT ----------------
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_last, busy;
  logic        mem_ce_n, mem_oe_n;
  logic [14:0] req_addr, mem_addr;
  logic [3:0]  req_len;
  logic [7:0]  rsp_data, mem_data;
  logic [1:0]  state_dbg;

  assign mem_data = mem_fn(mem_addr);

  eeprom_read_ctrl #(.WAIT_CYCLES(WAIT), .TURNAROUND(TA)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .state_dbg(state_dbg)
  );

  // ---------------- turnaround DUTs (always requesting) ----------------
  logic        rv_b, rr_b;
  logic [14:0] ra_b;
  logic [3:0]  rl_b;
  logic        qr3, sv3, sl3, bz3, ce3, oe3;
  logic        qr0, sv0, sl0, bz0, ce0, oe0;
  logic [7:0]  sd3, sd0, md3, md0;
  logic [14:0] ma3, ma0;
  logic [1:0]  st3, st0;

  assign md3 = mem_fn(ma3);
  assign md0 = mem_fn(ma0);

  eeprom_read_ctrl #(.WAIT_CYCLES(WAIT), .TURNAROUND(3)) dut_t3 (
    .clock(clock), .reset(reset),
    .req_valid(rv_b), .req_ready(qr3), .req_addr(ra_b), .req_len(rl_b),
    .rsp_valid(sv3), .rsp_ready(rr_b), .rsp_data(sd3), .rsp_last(sl3),
    .busy(bz3), .mem_addr(ma3), .mem_data(md3),
    .mem_ce_n(ce3), .mem_oe_n(oe3), .state_dbg(st3)
  );

  eeprom_read_ctrl #(.WAIT_CYCLES(WAIT), .TURNAROUND(0)) dut_t0 (
    .clock(clock), .reset(reset),
    .req_valid(rv_b), .req_ready(qr0), .req_addr(ra_b), .req_len(rl_b),
    .rsp_valid(sv0), .rsp_ready(rr_b), .rsp_data(sd0), .rsp_last(sl0),
    .busy(bz0), .mem_addr(ma0), .mem_data(md0),
    .mem_ce_n(ce0), .mem_oe_n(oe0), .state_dbg(st0)
  );

  initial begin
    rv_b = 1'b1;
    rr_b = 1'b1;
    ra_b = 15'h0010;
    rl_b = 4'd0;
  end

  // ---------------- checking ----------------
  int chk = 0;
  int err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard entry: {mem_addr[14:0], rsp_last, rsp_data[7:0]}
  logic [23:0] exp_q[$];
  logic        prev_last = 1'b1;
  int          last_hs = 0;
  int          rdy_mode = 0;   // 0: ready high, 1: random, 2: driven by hand
  int          en_mis = 0;

  task automatic push_burst(input logic [14:0] a, input logic [3:0] l);
    logic [14:0] x;
    x = a;
    for (int i = 0; i <= int'(l); i++) begin
      exp_q.push_back({x, 1'(i == int'(l)), mem_fn(x)});
      x = x + 15'd1;
    end
  endtask

  always @(negedge clock) begin
    logic [23:0] e;
    if (!reset) begin
      if (mem_ce_n !== mem_oe_n) en_mis++;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {24'd0, rsp_data}, 32'h0);
          chk--;  // counted once, keep the error
          chk++;
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(e[7:0]));
          check("rsp_last", 32'(rsp_last), 32'(e[8]));
          check("beat_addr", 32'(mem_addr), 32'(e[23:9]));
          if (rdy_mode == 0 && !prev_last)
            check("beat_spacing", 32'(cyc - last_hs), 32'(WAIT + 1));
          prev_last = e[8];
          last_hs   = cyc;
        end
      end
    end
  end

  // Turnaround gap / enable-low window measurement for the extra DUTs.
  int hi3 = 0, lo3 = 0, gap3 = 0, low3 = 0;
  int hi0 = 0, lo0 = 0, gap0 = 0, low0 = 0, mis_b = 0;
  always @(negedge clock) begin
    if (!reset) begin
      if (ce3 !== oe3 || ce0 !== oe0) mis_b++;
      if (ce3) begin
        hi3++;
        if (lo3 > 0) low3 = lo3;
        lo3 = 0;
      end else begin
        lo3++;
        if (hi3 > 0) gap3 = hi3;
        hi3 = 0;
      end
      if (ce0) begin
        hi0++;
        if (lo0 > 0) low0 = lo0;
        lo0 = 0;
      end else begin
        lo0++;
        if (hi0 > 0) gap0 = hi0;
        hi0 = 0;
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (rdy_mode == 1) rsp_ready = 1'($urandom_range(0, 1));
      else if (rdy_mode == 0) rsp_ready = 1'b1;
    end
  end

  // Queue the expected beats, present the request, return the cycle in
  // which it was accepted.
  task automatic do_req(input logic [14:0] a, input logic [3:0] l, output int t_acc);
    bit ok;
    ok = 0;
    t_acc = 0;
    push_burst(a, l);
    @(posedge clock);
    #1;
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (req_ready) begin
        ok = 1;
        t_acc = cyc;
        break;
      end
    end
    if (!ok) check("req_accept_timeout", 32'd1, 32'd0);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check("done_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [14:0] addr;
    logic [3:0]  len;
    logic        bp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int   t_acc, first_v, bad;
    bit   en_ok;
    logic [7:0]  d;
    logic [14:0] a;
    logic        l;
    bit   ok;

    vecs[0] = '{addr: 15'h7FFE, len: 4'd3,  bp: 1'b0};  // wrap 7FFE..0001
    vecs[1] = '{addr: 15'h0000, len: 4'd0,  bp: 1'b0};
    vecs[2] = '{addr: 15'h1234, len: 4'd15, bp: 1'b1};
    vecs[3] = '{addr: 15'h7FF8, len: 4'd15, bp: 1'b0};  // full burst, wraps
    vecs[4] = '{addr: 15'h4ABC, len: 4'd6,  bp: 1'b1};

    req_valid = 1'b0;
    req_addr  = 15'h0;
    req_len   = 4'h0;
    reset     = 1'b0;
    #1 reset  = 1'b1;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_ce_n",      32'(mem_ce_n),  32'd1);
    check("rst_oe_n",      32'(mem_oe_n),  32'd1);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_rsp_last",  32'(rsp_last),  32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Single read of the preloaded byte, with cycle-exact timing.
    rdy_mode = 0;
    do_req(15'h0123, 4'd0, t_acc);
    first_v = -1;
    en_ok   = 1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (rsp_valid && first_v < 0) first_v = cyc - t_acc;
      if (i <= 5 && (mem_ce_n || mem_oe_n)) en_ok = 0;
      if (i == 1) check("single_addr", 32'(mem_addr), 32'h0123);
      if (i == 5) begin
        check("single_data", 32'(rsp_data), 32'hA5);
        check("single_last", 32'(rsp_last), 32'd1);
      end
      if (i == 6) begin
        check("single_ce_after", 32'(mem_ce_n), 32'd1);
        check("single_ready_recover", 32'(req_ready), 32'd0);
      end
      if (i == 7) check("single_ready_back", 32'(req_ready), 32'd1);
    end
    check("single_first_valid", 32'(first_v), 32'(WAIT + 1));
    check("single_enables_low", 32'(en_ok), 32'd1);
    wait_done();

    // Table-driven bursts.
    foreach (vecs[k]) begin
      rdy_mode = vecs[k].bp ? 1 : 0;
      do_req(vecs[k].addr, vecs[k].len, t_acc);
      wait_done();
      if (!vecs[k].bp)
        check("burst_end_cycle", 32'(last_hs - t_acc),
              32'((int'(vecs[k].len) + 1) * (WAIT + 1)));
    end

    // Backpressure on beat 2 of a 3-beat burst.
    rdy_mode  = 2;
    rsp_ready = 1'b0;
    do_req(15'h2000, 4'd2, t_acc);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (rsp_valid) begin ok = 1; break; end
    end
    @(posedge clock); #1 rsp_ready = 1'b1;
    @(posedge clock); #1 rsp_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (rsp_valid) begin ok = ok & 1'b1; break; end
    end
    check("bp_reached_beat2", 32'(ok & rsp_valid), 32'd1);
    d = rsp_data;
    a = mem_addr;
    l = rsp_last;
    check("bp_addr", 32'(a), 32'h2001);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (rsp_data !== d || mem_addr !== a || rsp_last !== l ||
          mem_ce_n || mem_oe_n || !rsp_valid) bad++;
    end
    check("bp_stable", 32'(bad), 32'd0);
    @(posedge clock); #1 rsp_ready = 1'b1;
    wait_done();

    // Busy rejection: random request pulses during a burst, then a request
    // held valid that must be taken on the first IDLE cycle.
    rdy_mode = 0;
    do_req(15'h0300, 4'd3, t_acc);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      if (exp_q.size() == 0) break;
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = 15'($urandom_range(0, 32767));
      req_len   = 4'($urandom_range(0, 15));
      @(negedge clock);
      if (req_ready) bad++;
    end
    check("busy_req_ready_low", 32'(bad), 32'd0);
    push_burst(15'h0400, 4'd0);
    req_valid = 1'b1;
    req_addr  = 15'h0400;
    req_len   = 4'd0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (req_ready) begin ok = 1; break; end
    end
    check("held_accept_cycle", 32'(ok ? (cyc - last_hs) : -1), 32'(1 + TA));
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    check("held_accept_addr", 32'(mem_addr), 32'h0400);
    check("held_accept_ce", 32'(mem_ce_n), 32'd0);
    wait_done();

    // Reset during ACCESS of beat 2.
    do_req(15'h0500, 4'd3, t_acc);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (exp_q.size() == 3 && state_dbg == S_ACCESS) begin ok = 1; break; end
    end
    check("rst_mid_reached", 32'(ok), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_ce_n",      32'(mem_ce_n),  32'd1);
    check("rst_mid_oe_n",      32'(mem_oe_n),  32'd1);
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_busy",      32'(busy),      32'd0);
    check("rst_mid_mem_addr",  32'(mem_addr),  32'd0);
    exp_q.delete();
    prev_last = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    do_req(15'h0123, 4'd0, t_acc);
    wait_done();

    // Let the turnaround instances cycle a while, then inspect gaps.
    repeat (40) @(negedge clock);
    check("ta3_gap",  32'(gap3), 32'd4);
    check("ta0_gap",  32'(gap0), 32'd1);
    check("ta3_low",  32'(low3), 32'(WAIT + 1));
    check("ta0_low",  32'(low0), 32'(WAIT + 1));
    check("ta_ce_oe_match", 32'(mis_b), 32'd0);
    check("ce_oe_match", 32'(en_mis), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
